universal_shift_register: RTL and testbench
===========================================

// Module: universal_shift_register
// PURPOSE
//  Parametrised successor to the plain enabled register: a WIDTH-bit register
//  with a mode-selected next-state (hold, load, shift, rotate, sync clear).
//  Adds serial in/out on both ends and a saturating shift counter.
//  Used for serializer/deserializer front ends and LED/pattern datapaths
//  on the lab boards.
// PARAMETERS
//  WIDTH    4                  data width in bits, >= 2
//  CNT_W    $clog2(WIDTH+1)    shift counter width (derived, do not override)
// PORTS
//  clk       in   1      system clock, rising-edge active
//  clr       in   1      asynchronous active-high reset
//  en        in   1      clock enable; 0 = hold all state
//  mode      in   3      operation select (mode_t, see BEHAVIOUR)
//  D         in   WIDTH  parallel load data
//  sin_l     in   1      serial in at MSB end (used by SHR)
//  sin_r     in   1      serial in at LSB end (used by SHL)
//  Q         out  WIDTH  register contents
//  sout_l    out  1      Q[WIDTH-1], combinational from Q
//  sout_r    out  1      Q[0], combinational from Q
//  shift_cnt out  CNT_W  positions moved since last LOAD/CLEAR, saturating
//  full      out  1      shift_cnt == WIDTH, combinational from shift_cnt
// BEHAVIOUR
//  - One clock, clk; clr is asynchronous, active-high. clr=1: Q=0,
//    shift_cnt=0 immediately, regardless of clk/en. This holds mid-operation too.
//  - All state updates on rising clk only when en=1 and clr=0. Latency is 1 cycle.
//  - Modes when en=1:
//    000 HOLD  Q, cnt unchanged
//    001 LOAD  Q<=D; cnt<=0
//    010 SHL   Q<={Q[W-2:0],sin_r}; cnt<=sat(cnt+1)
//    011 SHR   Q<={sin_l,Q[W-1:1]}; cnt<=sat(cnt+1)
//    100 ROL   Q<={Q[W-2:0],Q[W-1]}; cnt<=sat(cnt+1)
//    101 ROR   Q<={Q[0],Q[W-1:1]}; cnt<=sat(cnt+1)
//    110 CLEAR synchronous clear: Q<=0; cnt<=0
//    111 rsvd  treated exactly as HOLD
//  - sat(x): min(x, WIDTH); cnt never wraps. full stays high until LOAD/CLEAR/clr.
//  - en=0 overrides mode: no change to Q or cnt, even for LOAD/CLEAR.
//  - No X propagation: an unknown mode falls to HOLD via the default case.
// CONFIGURATION
//  USHIFT_ROTATE_EN defined: ROL/ROR behave as above.
//  USHIFT_ROTATE_EN undefined: modes 100/101 act as HOLD; Q and cnt unchanged.
// STRUCTURE
//  Package ushift_pkg: typedef enum logic [2:0] mode_t {HOLD, LOAD, SHL,
//  SHR, ROL, ROR, CLEAR, RSVD}. Mode constants live only here.
//  Sub-module sat_counter #(MAX=WIDTH) holds the saturating count.
//  Ports: clk, clr, en, inc, zero, cnt. The datapath mux stays in the top.
// TESTING (WIDTH=4, USHIFT_ROTATE_EN defined unless noted)
//  1 en=0, mode=LOAD, D=7 for 2 clks -> Q=0, cnt=0. en=1 -> Q=4'b0111 next edge.
//  2 LOAD 4'b1001, then SHL sin_r=1 x1 -> Q=0011, cnt=1, sout_l=0.
//    Then SHR sin_l=1 -> Q=1001, cnt=2.
//  3 LOAD 4'b1000, ROL x4 -> Q=0001,0010,0100,1000. cnt=4, full=1.
//    ROL x2 more -> cnt stays 4.
//  4 mid-shift, clr pulse between edges -> Q=0, cnt=0 before next edge.
//    mode=CLEAR with en=1 -> Q=0 at the edge.
//  5 macro undefined: LOAD 4'b1000, ROL x2 -> Q=1000, cnt=0. mode=111 -> HOLD.

Source files
------------

// File: rtl/ushift_pkg.sv
// ushift_pkg: operation codes shared by the universal shift register and its bench.
package ushift_pkg;
  typedef enum logic [2:0] {HOLD, LOAD, SHL, SHR, ROL, ROR, CLEAR, RSVD} mode_t;
endpackage

// File: rtl/universal_shift_register_sat_counter.sv
// sat_counter: enabled counter that stops at MAX and returns to zero on request.
module sat_counter #(
  parameter int MAX = 4,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         inc,
  input  logic         zero,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = zero ? '0 : (inc && cnt_q != W'(MAX)) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge clr)
    if (clr) cnt_q <= '0;
    else if (en) cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/universal_shift_register.sv
// universal_shift_register: mode-selected WIDTH-bit register with serial ends and a saturating shift count.
// Rotate modes exist only when USHIFT_ROTATE_EN is defined; otherwise they hold.
module universal_shift_register
  import ushift_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] Q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             full
);
  logic [WIDTH-1:0] q_d, q_q;
  logic inc, zero;
  always_comb begin
    q_d = q_q;
    inc = 1'b0;
    zero = 1'b0;
    case (mode)
      LOAD:  begin q_d = D; zero = 1'b1; end
      SHL:   begin q_d = {q_q[WIDTH-2:0], sin_r}; inc = 1'b1; end
      SHR:   begin q_d = {sin_l, q_q[WIDTH-1:1]}; inc = 1'b1; end
`ifdef USHIFT_ROTATE_EN
      ROL:   begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; inc = 1'b1; end
      ROR:   begin q_d = {q_q[0], q_q[WIDTH-1:1]}; inc = 1'b1; end
`endif
      CLEAR: begin q_d = '0; zero = 1'b1; end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) q_q <= '0;
    else if (en) q_q <= q_d;
  sat_counter #(.MAX(WIDTH)) u_cnt (
    .clk(clk), .clr(clr), .en(en), .inc(inc), .zero(zero), .cnt(shift_cnt)
  );
  assign Q = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign full = shift_cnt == CNT_W'(WIDTH);
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: directed checks of the WIDTH=4 shift register in either rotate build.
module tb_universal_shift_register;
  import ushift_pkg::*;
  logic clk = 0, clr = 1, en = 0, sin_l = 0, sin_r = 0;
  logic [2:0] mode = HOLD;
  logic [3:0] D = '0, Q;
  logic sout_l, sout_r, full;
  logic [2:0] shift_cnt;
  int n_checks = 0, n_fail = 0;

  universal_shift_register #(.WIDTH(4)) dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .D(D), .sin_l(sin_l), .sin_r(sin_r),
    .Q(Q), .sout_l(sout_l), .sout_r(sout_r), .shift_cnt(shift_cnt), .full(full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (Q !== 4'b0000) begin n_fail++; $display("FAIL reset_q got=%b exp=0000", Q); end
    n_checks++; if (shift_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", shift_cnt); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    clr = 0;
  endtask

  task automatic test_enable();
    en = 0; mode = LOAD; D = 4'd7;
    tick(); tick();
    n_checks++; if (Q !== 4'b0000) begin n_fail++; $display("FAIL en0_load_q got=%b exp=0000", Q); end
    n_checks++; if (shift_cnt !== 3'd0) begin n_fail++; $display("FAIL en0_load_cnt got=%0d exp=0", shift_cnt); end
    en = 1;
    tick();
    n_checks++; if (Q !== 4'b0111) begin n_fail++; $display("FAIL en1_load_q got=%b exp=0111", Q); end
  endtask

  task automatic test_shift();
    mode = LOAD; D = 4'b1001;
    tick();
    mode = SHL; sin_r = 1;
    tick();
    n_checks++; if (Q !== 4'b0011) begin n_fail++; $display("FAIL shl_q got=%b exp=0011", Q); end
    n_checks++; if (shift_cnt !== 3'd1) begin n_fail++; $display("FAIL shl_cnt got=%0d exp=1", shift_cnt); end
    n_checks++; if (sout_l !== 1'b0 || sout_r !== 1'b1) begin n_fail++; $display("FAIL shl_sout got=%b%b exp=01", sout_l, sout_r); end
    mode = SHR; sin_l = 1; sin_r = 0;
    tick();
    n_checks++; if (Q !== 4'b1001) begin n_fail++; $display("FAIL shr_q got=%b exp=1001", Q); end
    n_checks++; if (shift_cnt !== 3'd2) begin n_fail++; $display("FAIL shr_cnt got=%0d exp=2", shift_cnt); end
    sin_l = 0;
  endtask

  task automatic test_saturate();
    mode = LOAD; D = 4'b0000;
    tick();
    mode = SHL; sin_r = 1;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (Q !== 4'b1111) begin n_fail++; $display("FAIL sat_q got=%b exp=1111", Q); end
    n_checks++; if (shift_cnt !== 3'd4 || full !== 1'b1) begin n_fail++; $display("FAIL sat_cnt got=%0d/%b exp=4/1", shift_cnt, full); end
    mode = LOAD; D = 4'b0101;
    tick();
    n_checks++; if (shift_cnt !== 3'd0 || full !== 1'b0) begin n_fail++; $display("FAIL load_zero got=%0d/%b exp=0/0", shift_cnt, full); end
    sin_r = 0;
  endtask

  task automatic test_rotate();
    logic [3:0] exp_q [4];
    exp_q[0] = 4'b0001; exp_q[1] = 4'b0010; exp_q[2] = 4'b0100; exp_q[3] = 4'b1000;
    mode = LOAD; D = 4'b1000;
    tick();
    mode = ROL;
`ifdef USHIFT_ROTATE_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (Q !== exp_q[i] || shift_cnt !== 3'(i + 1)) begin n_fail++; $display("FAIL rol_%0d got=%b/%0d exp=%b/%0d", i, Q, shift_cnt, exp_q[i], i + 1); end
    end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL rol_full got=%b exp=1", full); end
    tick(); tick();
    n_checks++; if (Q !== 4'b0010 || shift_cnt !== 3'd4) begin n_fail++; $display("FAIL rol_sat got=%b/%0d exp=0010/4", Q, shift_cnt); end
    mode = LOAD; D = 4'b0001;
    tick();
    mode = ROR;
    tick();
    n_checks++; if (Q !== 4'b1000 || shift_cnt !== 3'd1) begin n_fail++; $display("FAIL ror got=%b/%0d exp=1000/1", Q, shift_cnt); end
`else
    tick(); tick();
    n_checks++; if (Q !== 4'b1000 || shift_cnt !== 3'd0) begin n_fail++; $display("FAIL rol_off got=%b/%0d exp=1000/0", Q, shift_cnt); end
    mode = ROR;
    tick();
    n_checks++; if (Q !== 4'b1000 || shift_cnt !== 3'd0) begin n_fail++; $display("FAIL ror_off got=%b/%0d exp=1000/0", Q, shift_cnt); end
`endif
  endtask

  task automatic test_clear();
    mode = LOAD; D = 4'b1010;
    tick();
    mode = SHL; sin_r = 0;
    tick();
    n_checks++; if (Q !== 4'b0100 || shift_cnt !== 3'd1) begin n_fail++; $display("FAIL pre_clr got=%b/%0d exp=0100/1", Q, shift_cnt); end
    #2 clr = 1;
    #1;
    n_checks++; if (Q !== 4'b0000 || shift_cnt !== 3'd0) begin n_fail++; $display("FAIL async_clr got=%b/%0d exp=0000/0", Q, shift_cnt); end
    clr = 0;
    mode = LOAD; D = 4'b0110;
    tick();
    en = 0; mode = CLEAR;
    tick();
    n_checks++; if (Q !== 4'b0110) begin n_fail++; $display("FAIL en0_clear got=%b exp=0110", Q); end
    en = 1;
    tick();
    n_checks++; if (Q !== 4'b0000 || shift_cnt !== 3'd0) begin n_fail++; $display("FAIL sync_clear got=%b/%0d exp=0000/0", Q, shift_cnt); end
  endtask

  task automatic test_reserved();
    mode = LOAD; D = 4'b0101;
    tick();
    mode = SHL; sin_r = 1;
    tick();
    mode = RSVD;
    tick(); tick();
    n_checks++; if (Q !== 4'b1011 || shift_cnt !== 3'd1) begin n_fail++; $display("FAIL rsvd got=%b/%0d exp=1011/1", Q, shift_cnt); end
    mode = HOLD;
    tick();
    n_checks++; if (Q !== 4'b1011 || shift_cnt !== 3'd1) begin n_fail++; $display("FAIL hold got=%b/%0d exp=1011/1", Q, shift_cnt); end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_shift();
    test_saturate();
    test_rotate();
    test_clear();
    test_reserved();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
